brick_renderer: RTL and testbench

Brick-field state keeper and pixel generator for the Breakout display path. Sits directly downstream of the ball/collision engine: it consumes the per-hit erase events (`erase_enable`, `e_pos`, `active_data`) and keeps its own 10-entry damage table. Each display cycle it colours the current VGA pixel from that table, flags when every brick is gone, and (optionally) maintains a BCD score.

---
 rtl/brick_renderer_if.sv | 33 +++
 rtl/brick_renderer.sv | 156 +++++++++++++++
 tb/tb_brick_renderer.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/brick_renderer_if.sv
// Bus bundle between the collision engine / VGA timing and brick_renderer.
// The score signal exists only when BRICK_SCORE_EN is defined.
`timescale 1ns/1ps
interface brick_renderer_if;
  logic       erase_enable;
  logic [5:0] e_pos;
  logic [1:0] active_data;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic       video_on;
  logic [7:0] rgb;
  logic       brick_pixel;
  logic       all_cleared;
`ifdef BRICK_SCORE_EN
  logic [11:0] score;
`endif

  modport master (
    output erase_enable, e_pos, active_data, pixel_x, pixel_y, video_on,
    input  rgb, brick_pixel, all_cleared
`ifdef BRICK_SCORE_EN
    , input score
`endif
  );

  modport slave (
    input  erase_enable, e_pos, active_data, pixel_x, pixel_y, video_on,
    output rgb, brick_pixel, all_cleared
`ifdef BRICK_SCORE_EN
    , output score
`endif
  );
endinterface

// File: rtl/brick_renderer.sv
// Breakout brick-field damage table and pixel colouring; optional BCD score
// counter compiled in when BRICK_SCORE_EN is defined.
`timescale 1ns/1ps
module brick_renderer #(
  parameter int unsigned BLOCK_SPACING_X = 40,
  parameter int unsigned BLOCK_WIDTH     = 80,
  parameter int unsigned BLOCK_HEIGHT    = 30,
  parameter int unsigned FIRST_ROW_Y     = 40,
  parameter int unsigned SECOND_ROW_Y    = 90,
  parameter int unsigned NUM_BRICKS      = 10
) (
  input logic             clk,
  input logic             reset,
  brick_renderer_if.slave bus
);

  localparam int unsigned COLS  = 5;
  localparam int unsigned PITCH = BLOCK_SPACING_X + BLOCK_WIDTH;

  typedef enum logic [1:0] {
    LVL_INTACT  = 2'd0,
    LVL_CRACKED = 2'd1,
    LVL_BROKEN  = 2'd2,
    LVL_GONE    = 2'd3
  } level_t;

  level_t     table_q [NUM_BRICKS];
  level_t     table_d [NUM_BRICKS];
  logic [7:0] rgb_q, rgb_d;
  logic       brick_pixel_q, brick_pixel_d;
  logic       all_cleared_q, all_cleared_d;

  logic [10:0]     px, py;
  logic            in_row0, in_row1;
  logic [COLS-1:0] in_col;
  logic            pix_on_grid;
  level_t          pix_lvl;
  level_t          ev_lvl;
  logic            ev_valid;

  assign px = {1'b0, bus.pixel_x};
  assign py = {1'b0, bus.pixel_y};

  // Column decode by range compare against each brick's half-open extent.
  always_comb begin
    in_row0 = (py >= 11'(FIRST_ROW_Y))  && (py < 11'(FIRST_ROW_Y + BLOCK_HEIGHT));
    in_row1 = (py >= 11'(SECOND_ROW_Y)) && (py < 11'(SECOND_ROW_Y + BLOCK_HEIGHT));
    in_col  = '0;
    for (int unsigned c = 0; c < COLS; c++) begin
      in_col[c] = (px >= 11'(BLOCK_SPACING_X + c * PITCH)) &&
                  (px <  11'(BLOCK_SPACING_X + c * PITCH + BLOCK_WIDTH));
    end
  end

  always_comb begin
    pix_on_grid = 1'b0;
    pix_lvl     = LVL_GONE;
    for (int unsigned c = 0; c < COLS; c++) begin
      if (in_col[c]) begin
        if (in_row0) begin
          pix_on_grid = 1'b1;
          pix_lvl     = table_q[c];
        end else if (in_row1) begin
          pix_on_grid = 1'b1;
          pix_lvl     = table_q[c + COLS];
        end
      end
    end
  end

  always_comb begin
    rgb_d         = '0;
    brick_pixel_d = 1'b0;
    if (bus.video_on && pix_on_grid) begin
      case (pix_lvl)
        LVL_INTACT:  begin rgb_d = 8'hE0; brick_pixel_d = 1'b1; end
        LVL_CRACKED: begin rgb_d = 8'hFC; brick_pixel_d = 1'b1; end
        LVL_BROKEN:  begin rgb_d = 8'h1C; brick_pixel_d = 1'b1; end
        default:     begin rgb_d = '0;    brick_pixel_d = 1'b0; end
      endcase
    end
  end

  // Out-of-range indices match no entry, so ev_lvl stays GONE and the event drops.
  always_comb begin
    ev_lvl = LVL_GONE;
    for (int unsigned i = 0; i < NUM_BRICKS; i++) begin
      if (bus.e_pos == 6'(i)) ev_lvl = table_q[i];
    end
    ev_valid = bus.erase_enable && (bus.e_pos < 6'(NUM_BRICKS)) &&
               (bus.active_data != 2'd0) && (ev_lvl != LVL_GONE);
    all_cleared_d = 1'b1;
    for (int unsigned i = 0; i < NUM_BRICKS; i++) begin
      table_d[i] = table_q[i];
      if (ev_valid && (bus.e_pos == 6'(i))) table_d[i] = level_t'(bus.active_data);
      if (table_d[i] != LVL_GONE) all_cleared_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_BRICKS; i++) table_q[i] <= LVL_INTACT;
      rgb_q         <= '0;
      brick_pixel_q <= 1'b0;
      all_cleared_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_BRICKS; i++) table_q[i] <= table_d[i];
      rgb_q         <= rgb_d;
      brick_pixel_q <= brick_pixel_d;
      all_cleared_q <= all_cleared_d;
    end
  end

  assign bus.rgb         = rgb_q;
  assign bus.brick_pixel = brick_pixel_q;
  assign bus.all_cleared = all_cleared_q;

`ifdef BRICK_SCORE_EN
  logic [11:0] score_q, score_d;
  logic [12:0] score_sum;

  // Three-digit BCD add; bit 12 is the carry out of the hundreds digit.
  function automatic logic [12:0] bcd_add3(input logic [11:0] v, input logic [3:0] inc);
    logic [4:0]  d;
    logic        carry;
    logic [11:0] r;
    carry = 1'b0;
    r     = '0;
    for (int unsigned k = 0; k < 3; k++) begin
      d = {1'b0, v[4*k +: 4]} + ((k == 0) ? {1'b0, inc} : {4'd0, carry});
      if (d > 5'd9) begin
        d     = d - 5'd10;
        carry = 1'b1;
      end else begin
        carry = 1'b0;
      end
      r[4*k +: 4] = d[3:0];
    end
    return {carry, r};
  endfunction

  always_comb begin
    score_sum = bcd_add3(score_q, (bus.active_data == 2'd3) ? 4'd5 : 4'd1);
    score_d   = score_q;
    if (ev_valid) score_d = score_sum[12] ? 12'h999 : score_sum[11:0];
  end

  always_ff @(posedge clk) begin
    if (reset) score_q <= '0;
    else       score_q <= score_d;
  end

  assign bus.score = score_q;
`endif

endmodule

// File: tb/tb_brick_renderer.sv
// Self-checking bench for brick_renderer: fixed pixel vectors, directed
// event sequences and a randomized phase against an arithmetic reference model.
`timescale 1ns/1ps
module tb_brick_renderer;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  brick_renderer_if bus ();

  brick_renderer #(
    .BLOCK_SPACING_X(40),
    .BLOCK_WIDTH(80),
    .BLOCK_HEIGHT(30),
    .FIRST_ROW_Y(40),
    .SECOND_ROW_Y(90),
    .NUM_BRICKS(10)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference model state
  int         lvl [10];
  int         score_m;
  logic       clr_m;
  logic [7:0] exp_rgb;
  logic       exp_bp;

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic       von;
    logic [7:0] rgb;
    logic       bp;
  } pix_vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic int pix_brick(input int x, input int y);
    int row, col;
    if (y >= 40 && y < 70) row = 0;
    else if (y >= 90 && y < 120) row = 1;
    else return -1;
    if (x < 40) return -1;
    if (((x - 40) % 120) >= 80) return -1;
    col = (x - 40) / 120;
    if (col >= 5) return -1;
    return row * 5 + col;
  endfunction

  function automatic logic [7:0] lvl_colour(input int l);
    case (l)
      0: return 8'hE0;
      1: return 8'hFC;
      2: return 8'h1C;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [11:0] to_bcd(input int s);
    return 12'((s / 100) * 256 + ((s / 10) % 10) * 16 + (s % 10));
  endfunction

  // Predict outputs from current inputs and model, advance model, clock once.
  task automatic tick(input bit chk);
    int b, p, d;
    b = pix_brick(int'(bus.pixel_x), int'(bus.pixel_y));
    if (reset || !bus.video_on || b < 0) begin
      exp_rgb = 8'h00; exp_bp = 1'b0;
    end else if (lvl[b] == 3) begin
      exp_rgb = 8'h00; exp_bp = 1'b0;
    end else begin
      exp_rgb = lvl_colour(lvl[b]); exp_bp = 1'b1;
    end
    p = int'(bus.e_pos);
    d = int'(bus.active_data);
    if (reset) begin
      foreach (lvl[i]) lvl[i] = 0;
      score_m = 0;
    end else if (bus.erase_enable && p < 10 && d != 0) begin
      if (lvl[p] != 3) begin
        lvl[p]  = d;
        score_m = score_m + ((d == 3) ? 5 : 1);
        if (score_m > 999) score_m = 999;
      end
    end
    clr_m = !reset;
    foreach (lvl[i]) if (lvl[i] != 3) clr_m = 1'b0;
    @(posedge clk); #1;
    if (chk) begin
      check("rgb", 32'(bus.rgb), 32'(exp_rgb));
      check("brick_pixel", 32'(bus.brick_pixel), 32'(exp_bp));
      check("all_cleared", 32'(bus.all_cleared), 32'(clr_m));
`ifdef BRICK_SCORE_EN
      check("score", 32'(bus.score), 32'(to_bcd(score_m)));
`endif
    end
  endtask

  task automatic set_pix(input int x, input int y, input logic von);
    bus.pixel_x  = 10'(x);
    bus.pixel_y  = 10'(y);
    bus.video_on = von;
  endtask

  task automatic set_ev(input logic en, input int pos, input int data);
    bus.erase_enable = en;
    bus.e_pos        = 6'(pos);
    bus.active_data  = 2'(data);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_ev(1'b0, 0, 0);
    tick(1'b1);
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    pix_vec_t vecs [12];
    vecs[0]  = '{10'd40,  10'd40,  1'b1, 8'hE0, 1'b1};
    vecs[1]  = '{10'd120, 10'd40,  1'b1, 8'h00, 1'b0};
    vecs[2]  = '{10'd39,  10'd40,  1'b1, 8'h00, 1'b0};
    vecs[3]  = '{10'd119, 10'd69,  1'b1, 8'hE0, 1'b1};
    vecs[4]  = '{10'd119, 10'd70,  1'b1, 8'h00, 1'b0};
    vecs[5]  = '{10'd160, 10'd40,  1'b1, 8'hE0, 1'b1};
    vecs[6]  = '{10'd520, 10'd90,  1'b1, 8'hE0, 1'b1};
    vecs[7]  = '{10'd599, 10'd119, 1'b1, 8'hE0, 1'b1};
    vecs[8]  = '{10'd600, 10'd119, 1'b1, 8'h00, 1'b0};
    vecs[9]  = '{10'd40,  10'd39,  1'b1, 8'h00, 1'b0};
    vecs[10] = '{10'd300, 10'd100, 1'b0, 8'h00, 1'b0};
    vecs[11] = '{10'd300, 10'd80,  1'b1, 8'h00, 1'b0};

    foreach (lvl[i]) lvl[i] = 0;
    score_m = 0;
    clr_m   = 1'b0;
    set_pix(40, 40, 1'b1);
    set_ev(1'b0, 0, 0);

    // Reset state
    do_reset();
    do_reset();
    check("rst_rgb", 32'(bus.rgb), 32'h00);
    check("rst_bp", 32'(bus.brick_pixel), 32'h0);
    check("rst_clr", 32'(bus.all_cleared), 32'h0);

    // Fixed pixel table on an intact field
    for (int i = 0; i < 12; i++) begin
      set_pix(int'(vecs[i].x), int'(vecs[i].y), vecs[i].von);
      tick(1'b1);
      check($sformatf("vec%0d_rgb", i), 32'(bus.rgb), 32'(vecs[i].rgb));
      check($sformatf("vec%0d_bp", i), 32'(bus.brick_pixel), 32'(vecs[i].bp));
    end

    // Brick 7 damaged then destroyed
    set_pix(300, 100, 1'b1);
    set_ev(1'b1, 7, 1); tick(1'b1);
    set_ev(1'b0, 0, 0); tick(1'b1);
    check("b7_yellow", 32'(bus.rgb), 32'hFC);
    set_ev(1'b1, 7, 3); tick(1'b1);
    set_ev(1'b0, 0, 0); tick(1'b1);
    check("b7_gone", 32'(bus.rgb), 32'h00);
    check("b7_gone_bp", 32'(bus.brick_pixel), 32'h0);
`ifdef BRICK_SCORE_EN
    check("score6", 32'(bus.score), 32'h006);
`endif

    // Invalid events
    set_ev(1'b1, 12, 1); tick(1'b1);
    set_ev(1'b1, 3, 0);  tick(1'b1);
    set_ev(1'b1, 7, 1);  tick(1'b1);
    set_ev(1'b0, 0, 0);
    set_pix(400, 40, 1'b1); tick(1'b1);
    check("b3_intact", 32'(bus.rgb), 32'hE0);
    set_pix(300, 100, 1'b1); tick(1'b1);
    check("b7_still_gone", 32'(bus.rgb), 32'h00);
`ifdef BRICK_SCORE_EN
    check("score_hold", 32'(bus.score), 32'h006);
`endif

    // Same-cycle event and lookup on brick 0
    set_pix(50, 50, 1'b1);
    set_ev(1'b1, 0, 2); tick(1'b1);
    check("same_cyc_old", 32'(bus.rgb), 32'hE0);
    set_ev(1'b0, 0, 0); tick(1'b1);
    check("same_cyc_new", 32'(bus.rgb), 32'h1C);

    // Randomized phase against the model
    do_reset();
    for (int k = 0; k < 400; k++) begin
      set_ev(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
             ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2)));
      if ($urandom_range(0, 1) == 1)
        set_pix(int'($urandom_range(0, 639)), int'($urandom_range(0, 150)),
                1'($urandom_range(0, 7) != 0));
      else
        set_pix(40 + 120 * int'($urandom_range(0, 4)) + int'($urandom_range(0, 79)),
                (($urandom_range(0, 1) == 1) ? 90 : 40) + int'($urandom_range(0, 29)), 1'b1);
      tick(1'b1);
    end
    set_ev(1'b0, 0, 0);

    // Back-to-back destruction of all bricks
    do_reset();
    set_pix(40, 40, 1'b1);
    for (int i = 0; i < 10; i++) begin
      set_ev(1'b1, i, 3);
      tick(1'b1);
      check($sformatf("clr_step%0d", i), 32'(bus.all_cleared), (i == 9) ? 32'h1 : 32'h0);
    end
    set_ev(1'b0, 0, 0);
`ifdef BRICK_SCORE_EN
    check("score50", 32'(bus.score), 32'h050);
`endif
    reset = 1'b1; tick(1'b1);
    check("clr_after_rst", 32'(bus.all_cleared), 32'h0);
`ifdef BRICK_SCORE_EN
    check("score_after_rst", 32'(bus.score), 32'h000);
`endif
    reset = 1'b0; tick(1'b1);
    check("b0_restored", 32'(bus.rgb), 32'hE0);

`ifdef BRICK_SCORE_EN
    // Saturation: alternating levels 1/2 on brick 0 never destroys it
    do_reset();
    for (int k = 0; k < 1000; k++) begin
      set_ev(1'b1, 0, (k % 2) + 1);
      tick(1'b0);
    end
    set_ev(1'b1, 1, 3); tick(1'b1);
    set_ev(1'b0, 0, 0); tick(1'b1);
    check("score_sat", 32'(bus.score), 32'h999);
`endif

    // Blanking
    set_pix(40, 40, 1'b0); tick(1'b1);
    check("blank_rgb", 32'(bus.rgb), 32'h00);
    check("blank_bp", 32'(bus.brick_pixel), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
